mmm_rshift_acc: RTL

Parametrised Montgomery partial-result accumulator register for the RSA MMM datapath. It holds the running sum between adder passes and loads the adder output right-shifted by SHIFT bits (radix 2^SHIFT) on every enabled step. An internal step counter sequences exactly STEPS iterations and raises a done flag. It also checks that the shifted-out digit is zero and, optionally, applies the final conditional modulus subtraction.

---
 rtl/mmm_rshift_acc.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mmm_rshift_acc.sv
// Montgomery partial-result accumulator: loads (rjo >> SHIFT) per enabled step over STEPS steps,
// flags nonzero shifted-out digits; MMM_FINAL_SUB_EN adds a registered final conditional subtract.
module mmm_rshift_acc #(
  parameter  int WIDTH = 8,
  parameter  int SHIFT = 1,
  parameter  int STEPS = 8,
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             rst_mmm_i,
  input  logic             start,
  input  logic             en,
  input  logic [WIDTH-1:0] rjo,
  input  logic [WIDTH-1:0] mod_i,
  output logic [WIDTH-1:0] reg_rji,
  output logic [SW-1:0]    step_o,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  // Either reset source clears everything asynchronously.
  logic clr_n;
  assign clr_n = rstb & rst_mmm_i;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    step_q, step_d;
  logic             err_q, err_d;

`ifdef MMM_FINAL_SUB_EN
  logic [WIDTH-1:0] res_q, res_d;
  localparam state_t LAST_NEXT = S_SUB;
`else
  localparam state_t LAST_NEXT = S_DONE;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      step_q  <= '0;
      err_q   <= 1'b0;
`ifdef MMM_FINAL_SUB_EN
      res_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      err_q   <= err_d;
`ifdef MMM_FINAL_SUB_EN
      res_q   <= res_d;
`endif
    end
  end

  // start pre-empts every state; en only matters in RUN.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    step_d  = step_q;
    err_d   = err_q;
`ifdef MMM_FINAL_SUB_EN
    res_d   = res_q;
`endif
    if (start) begin
      state_d = S_RUN;
      acc_d   = '0;
      step_d  = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (en) begin
            acc_d = rjo >> SHIFT;
            if (rjo[SHIFT-1:0] != '0) err_d = 1'b1;
            if (step_q == LAST_STEP) state_d = LAST_NEXT;
            else                     step_d  = step_q + SW'(1);
          end
        end
`ifdef MMM_FINAL_SUB_EN
        S_SUB: begin
          res_d   = (acc_q >= mod_i) ? (acc_q - mod_i) : acc_q;
          state_d = S_DONE;
        end
`endif
        default: ;
      endcase
    end
  end

  assign reg_rji = acc_q;
  assign step_o  = step_q;
  assign err     = err_q;
  assign busy    = (state_q == S_RUN) || (state_q == S_SUB);
  assign done    = (state_q == S_DONE);
  assign state_o = state_q;

`ifdef MMM_FINAL_SUB_EN
  assign result_o = res_q;
`else
  assign result_o = acc_q;
  logic unused_mod;
  assign unused_mod = ^mod_i;
`endif

endmodule
